inta_sequencer: RTL and testbench
=================================

INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have parameter INTA_TIMEOUT, default 255, meaning the maximum clk cycles allowed between INTA pulses before the sequence aborts.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port inta_n, input, 1 bit: CPU interrupt acknowledge, active-low, already synchronous to clk.
REQ-005 SHALL have port int_req, input, 1 bit: priority resolver reports an unmasked request above the current in-service level.
REQ-006 SHALL have port int_level, input, 3 bits: highest-priority pending IR level.
REQ-007 SHALL have port icw2, input, 8 bits: vector base (T7-T3), or CALL high byte in 8080 mode.
REQ-008 SHALL have port addr_low, input, 3 bits: ICW1 A7-A5, used only in 8080 mode.
REQ-009 SHALL have port aeoi, input, 1 bit: automatic EOI enable (ICW4).
REQ-010 SHALL have port upm, input, 1 bit: 1 = 8086 mode, 0 = 8080 mode.
REQ-011 SHALL have ports eoi_valid (input, 1 bit) and eoi_level (input, 3 bits): specific or resolved EOI from OCW2 handling.
REQ-012 SHALL have port int_out, output, 1 bit: INT pin to the CPU.
REQ-013 SHALL have port isr, output, 8 bits: in-service register.
REQ-014 SHALL have ports freeze (output, 1 bit), latch_in_service (output, 1 bit, pulse) and clear_irr (output, 8 bits, one-hot pulse).
REQ-015 SHALL have ports data_out (output, 8 bits), data_oe (output, 1 bit) and ack_done (output, 1 bit, pulse).

Function
REQ-016 SHALL implement states IDLE, REQ, ACK1, GAP, ACK2 and, with the macro defined, GAP2 and ACK3.
REQ-017 SHALL detect an INTA falling edge as inta_n=0 with the registered previous sample equal to 1; the rising edge is the inverse.
REQ-018 IDLE: when int_req=1, SHALL move to REQ and assert int_out on the next cycle.
REQ-019 REQ: on a falling edge, SHALL deassert int_out, assert freeze, latch the level and enter ACK1.
REQ-020 ACK1 entry: if int_req=1, SHALL set isr[level], pulse clear_irr[level] and pulse latch_in_service for 1 cycle.
REQ-021 ACK1 entry: if int_req=0 (spurious), SHALL latch level 7 and leave isr and clear_irr untouched.
REQ-022 ACK1, 8086 mode: data_oe=0 throughout. On the rising edge, go to GAP.
REQ-023 ACK2, 8086 mode: data_out={icw2[7:3], level}, with data_oe=1 while inta_n=0.
REQ-024 On the rising edge of the last pulse: clear isr[level] if aeoi=1 and not spurious; drop freeze; pulse ack_done; return to IDLE.
REQ-025 GAP and GAP2: a cycle counter SHALL abort to IDLE when it reaches INTA_TIMEOUT, with freeze=0, isr retained and no ack_done.
REQ-026 eoi_valid SHALL clear isr[eoi_level] in any state; a simultaneous set of the same bit SHALL win.
REQ-027 data_oe SHALL be 0 outside the ACK data phases; data_out SHALL hold 8'h00 when data_oe=0.

Reset
REQ-028 reset SHALL force IDLE with int_out=0, isr=0, freeze=0, latch_in_service=0, clear_irr=0, data_out=0, data_oe=0, ack_done=0, counter=0, and the edge register=1; this applies mid-sequence too.

Configuration
REQ-029 With MODE_8080_EN defined: when upm=0, ACK1 SHALL drive 8'hCD, ACK2 {addr_low, level, 2'b00}, and ACK3 icw2, each with data_oe=1 while inta_n=0.
REQ-030 Without MODE_8080_EN: GAP2 and ACK3 SHALL be absent, and upm SHALL be ignored (8086 behaviour always).

Structure
REQ-031 A shared package SHALL hold the state enum typedef, the CALL_OPCODE=8'hCD constant and the SPURIOUS_LEVEL=3'd7 constant.
REQ-032 The INTA edge detector plus timeout counter SHALL form one sub-module, inta_edge_timer.

Verification
REQ-033 8086 mode, icw2=8'h40, int_level=3, two INTA pulses -> isr=8'h08 and clear_irr=8'h08 at pulse 1; data_out=8'h43 at pulse 2.
REQ-034 The same stimulus with aeoi=1 -> isr returns to 8'h00 on the second rising edge, and ack_done pulses once.
REQ-035 int_req drops before the first INTA -> vector 8'h47, isr stays 8'h00, clear_irr stays 0.
REQ-036 MODE_8080_EN, upm=0, addr_low=3'b101, icw2=8'h12, level 2 -> bytes 8'hCD, 8'hA8, 8'h12.
REQ-037 No second INTA for 255 cycles -> IDLE, freeze=0, isr retained; eoi_valid with level 3 then clears isr.
REQ-038 Reset asserted during ACK1 -> all outputs are zero on the next cycle.

Source files
------------

// File: rtl/inta_sequencer_pkg.sv
// inta_sequencer_pkg -- shared types and constants for the INTA sequencer.
//   state_t        : sequencer state encoding (GAP2/ACK3 only with MODE_8080_EN)
//   CALL_OPCODE    : first byte driven in 8080 mode
//   SPURIOUS_LEVEL : level reported when the request vanished before INTA
// Optional feature macro: MODE_8080_EN (three-pulse 8080 CALL sequence).
package inta_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ACK1 = 3'd2,
    ST_GAP  = 3'd3,
    ST_ACK2 = 3'd4
`ifdef MODE_8080_EN
    ,
    ST_GAP2 = 3'd5,
    ST_ACK3 = 3'd6
`endif
  } state_t;

  localparam logic [7:0] CALL_OPCODE    = 8'hCD;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  function automatic logic [7:0] onehot8(input logic [2:0] l);
    return 8'h01 << l;
  endfunction

endpackage

// File: rtl/inta_sequencer_edge_timer.sv
// inta_edge_timer -- INTA edge detector plus inter-pulse timeout counter.
//   clk, reset     : clock, synchronous active-high reset
//   i_inta_n       : INTA from CPU (active low, already synchronous)
//   i_cnt_en       : count while the sequencer waits between pulses
//   o_fall, o_rise : INTA falling / rising edge, same cycle as the new sample
//   o_timeout      : counter has reached TIMEOUT while counting
module inta_edge_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inta_n,
  input  logic i_cnt_en,
  output logic o_fall,
  output logic o_rise,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic          r_inta_d;
  logic [CW-1:0] r_cnt;

  // Previous sample resets to 1 so a low INTA held through reset is not
  // mistaken for a fresh falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inta_d <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_inta_d <= i_inta_n;
      if (!i_cnt_en)
        r_cnt <= '0;
      else if (!o_timeout)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_fall    = ~i_inta_n & r_inta_d;
  assign o_rise    = i_inta_n & ~r_inta_d;
  assign o_timeout = i_cnt_en && (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/inta_sequencer.sv
// inta_sequencer -- 8259-style interrupt acknowledge sequencer.
// Raises INT on a resolved request, walks the INTA pulses, maintains the
// in-service register and drives the vector bytes onto the data bus.
//   clk, reset           : clock, synchronous active-high reset
//   inta_n               : CPU interrupt acknowledge (active low)
//   int_req, int_level   : resolver request and its level
//   icw2, addr_low       : vector base / CALL high byte, 8080 A7-A5
//   aeoi, upm            : auto-EOI, 8086 (1) / 8080 (0) mode
//   eoi_valid, eoi_level : EOI command clearing one ISR bit
//   int_out, isr, freeze, latch_in_service, clear_irr : control outputs
//   data_out, data_oe, ack_done                        : bus side
// Optional feature macro: MODE_8080_EN. Without it upm is ignored and the
// sequence is always the two-pulse 8086 form.
module inta_sequencer
  import inta_sequencer_pkg::*;
#(
  parameter int INTA_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inta_n,
  input  logic       int_req,
  input  logic [2:0] int_level,
  input  logic [7:0] icw2,
  input  logic [2:0] addr_low,
  input  logic       aeoi,
  input  logic       upm,
  input  logic       eoi_valid,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] isr,
  output logic       freeze,
  output logic       latch_in_service,
  output logic [7:0] clear_irr,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       ack_done
);

  state_t     r_state;
  logic [2:0] r_lvl;
  logic       r_spur;

  logic       w_fall, w_rise, w_timeout, w_cnt_en;
  logic       w_m80, w_finish;
  logic [7:0] w_byte2;

`ifdef MODE_8080_EN
  assign w_m80    = ~upm;
  assign w_byte2  = w_m80 ? {addr_low, r_lvl, 2'b00} : {icw2[7:3], r_lvl};
  assign w_cnt_en = (r_state == ST_GAP) || (r_state == ST_GAP2);
  assign w_finish = w_rise && ((r_state == ST_ACK2 && !w_m80) || r_state == ST_ACK3);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = &{1'b0, upm, addr_low, icw2[2:0]};
  assign w_m80        = 1'b0;
  assign w_byte2      = {icw2[7:3], r_lvl};
  assign w_cnt_en     = (r_state == ST_GAP);
  assign w_finish     = w_rise && (r_state == ST_ACK2);
`endif

  inta_edge_timer #(.TIMEOUT(INTA_TIMEOUT)) u_edge_timer (
    .clk       (clk),
    .reset     (reset),
    .i_inta_n  (inta_n),
    .i_cnt_en  (w_cnt_en),
    .o_fall    (w_fall),
    .o_rise    (w_rise),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_lvl            <= '0;
      r_spur           <= 1'b0;
      int_out          <= 1'b0;
      isr              <= '0;
      freeze           <= 1'b0;
      latch_in_service <= 1'b0;
      clear_irr        <= '0;
      data_out         <= '0;
      data_oe          <= 1'b0;
      ack_done         <= 1'b0;
    end else begin
      latch_in_service <= 1'b0;
      clear_irr        <= '0;
      ack_done         <= 1'b0;

      // EOI first so that a set of the same bit later in this block wins.
      if (eoi_valid) isr[eoi_level] <= 1'b0;

      if (w_finish) begin
        if (aeoi && !r_spur) isr[r_lvl] <= 1'b0;
        freeze   <= 1'b0;
        ack_done <= 1'b1;
        data_oe  <= 1'b0;
        data_out <= '0;
        r_state  <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: if (int_req) begin
            int_out <= 1'b1;
            r_state <= ST_REQ;
          end
          ST_REQ: if (w_fall) begin
            int_out <= 1'b0;
            freeze  <= 1'b1;
            r_spur  <= ~int_req;
            r_state <= ST_ACK1;
            // Request withdrawn before INTA: report the spurious level and
            // leave ISR / IRR alone.
            if (int_req) begin
              r_lvl            <= int_level;
              isr[int_level]   <= 1'b1;
              clear_irr        <= onehot8(int_level);
              latch_in_service <= 1'b1;
            end else begin
              r_lvl <= SPURIOUS_LEVEL;
            end
            if (w_m80) begin
              data_out <= CALL_OPCODE;
              data_oe  <= 1'b1;
            end
          end
          ST_ACK1: if (w_rise) begin
            data_oe  <= 1'b0;
            data_out <= '0;
            r_state  <= ST_GAP;
          end
          ST_GAP: begin
            if (w_fall) begin
              data_out <= w_byte2;
              data_oe  <= 1'b1;
              r_state  <= ST_ACK2;
            end else if (w_timeout) begin
              freeze  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
`ifdef MODE_8080_EN
          // Only the 8080 path reaches here without finishing.
          ST_ACK2: if (w_rise) begin
            data_oe  <= 1'b0;
            data_out <= '0;
            r_state  <= ST_GAP2;
          end
          ST_GAP2: begin
            if (w_fall) begin
              data_out <= icw2;
              data_oe  <= 1'b1;
              r_state  <= ST_ACK3;
            end else if (w_timeout) begin
              freeze  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inta_n = 1'b1;
  logic       int_req = 1'b0;
  logic [2:0] int_level = 3'd0;
  logic [7:0] icw2 = 8'h00;
  logic [2:0] addr_low = 3'd0;
  logic       aeoi = 1'b0;
  logic       upm = 1'b1;
  logic       eoi_valid = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       int_out, freeze, latch_in_service, data_oe, ack_done;
  logic [7:0] isr, clear_irr, data_out;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;
  logic [7:0] m_isr = 8'h00;   // reference in-service register

  inta_sequencer #(.INTA_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .inta_n(inta_n), .int_req(int_req),
    .int_level(int_level), .icw2(icw2), .addr_low(addr_low), .aeoi(aeoi),
    .upm(upm), .eoi_valid(eoi_valid), .eoi_level(eoi_level),
    .int_out(int_out), .isr(isr), .freeze(freeze),
    .latch_in_service(latch_in_service), .clear_irr(clear_irr),
    .data_out(data_out), .data_oe(data_oe), .ack_done(ack_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ack_done === 1'b1) ack_cnt <= ack_cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_eoi(input logic [2:0] l);
    eoi_valid = 1'b1;
    eoi_level = l;
    step(1);
    eoi_valid = 1'b0;
    m_isr &= ~(8'h01 << l);
    chk("eoi_isr", isr, m_isr);
  endtask

  // One complete 8086-style acknowledge, checked against the model.
  task automatic run_txn(input logic [2:0] lvl, input logic [7:0] vb, input logic ae,
                         input logic spur, input logic eoi_same, input int gap, input int hold);
    logic [2:0] el;
    logic [7:0] oh;
    int a0;
    el = spur ? 3'd7 : lvl;
    oh = spur ? 8'h00 : (8'h01 << lvl);
    icw2 = vb; aeoi = ae; int_level = lvl; int_req = 1'b1; a0 = ack_cnt;
    step(1);
    chk("int_out_raised", {7'b0, int_out}, 8'h01);
    if (spur) int_req = 1'b0;
    if (eoi_same) begin
      eoi_valid = 1'b1;
      eoi_level = lvl;
    end
    inta_n = 1'b0;
    step(1);
    eoi_valid = 1'b0;
    m_isr |= oh;
    chk("ack1_isr", isr, m_isr);
    chk("ack1_clear_irr", clear_irr, oh);
    chk("ack1_latch", {7'b0, latch_in_service}, {7'b0, ~spur});
    chk("ack1_frz_int_oe", {5'b0, freeze, int_out, data_oe}, 8'b100);
    int_req = 1'b0;
    step(1);
    chk("pulse_one_cycle", {7'b0, latch_in_service} | clear_irr, 8'h00);
    inta_n = 1'b1;
    step(1 + gap);
    chk("gap_bus_idle", data_out | {7'b0, data_oe}, 8'h00);
    chk("gap_freeze", {7'b0, freeze}, 8'h01);
    inta_n = 1'b0;
    step(1);
    chk("vector", data_out, {vb[7:3], el});
    chk("vector_oe", {7'b0, data_oe}, 8'h01);
    step(hold);
    inta_n = 1'b1;
    step(1);
    if (ae && !spur) m_isr &= ~oh;
    chk("end_isr", isr, m_isr);
    chk("end_done_frz_oe", {5'b0, ack_done, freeze, data_oe}, 8'b100);
    step(1);
    chk("ack_done_once", 8'(ack_cnt - a0), 8'h01);
  endtask

  initial begin
    int a0;
    step(2);
    chk("reset_isr", isr, 8'h00);
    chk("reset_ctl", {int_out, freeze, latch_in_service, data_oe, ack_done, 3'b0}, 8'h00);
    chk("reset_bus", data_out | clear_irr, 8'h00);
    reset = 1'b0;
    step(1);

    // Basic 8086 vector, no auto-EOI.
    run_txn(3'd3, 8'h40, 1'b0, 1'b0, 1'b0, 2, 1);
    do_eoi(3'd3);
    // Auto-EOI returns ISR to zero.
    run_txn(3'd3, 8'h40, 1'b1, 1'b0, 1'b0, 0, 0);
    // Spurious: request withdrawn before INTA.
    run_txn(3'd3, 8'h40, 1'b0, 1'b1, 1'b0, 1, 0);
    // EOI on the same bit as the set: set wins.
    run_txn(3'd5, 8'h88, 1'b0, 1'b0, 1'b1, 0, 2);
    do_eoi(3'd5);

    // Timeout while waiting for the second pulse.
    icw2 = 8'h40; aeoi = 1'b0; int_level = 3'd3; int_req = 1'b1; a0 = ack_cnt;
    step(1);
    inta_n = 1'b0;
    step(1);
    m_isr |= 8'h08;
    int_req = 1'b0;
    inta_n = 1'b1;
    step(1);
    step(250);
    chk("timeout_still_waiting", {7'b0, freeze}, 8'h01);
    step(10);
    chk("timeout_freeze", {7'b0, freeze}, 8'h00);
    chk("timeout_isr", isr, m_isr);
    chk("timeout_no_done", 8'(ack_cnt - a0), 8'h00);
    do_eoi(3'd3);
    // Sequencer must be usable again after an abort.
    run_txn(3'd1, 8'hF8, 1'b0, 1'b0, 1'b0, 3, 0);

    // Reset in the middle of ACK1.
    int_level = 3'd2; int_req = 1'b1;
    step(1);
    inta_n = 1'b0;
    step(1);
    reset = 1'b1; inta_n = 1'b1; int_req = 1'b0;
    step(1);
    m_isr = 8'h00;
    chk("midrst_isr", isr, 8'h00);
    chk("midrst_ctl", {int_out, freeze, latch_in_service, data_oe, ack_done, 3'b0}, 8'h00);
    chk("midrst_bus", data_out | clear_irr, 8'h00);
    reset = 1'b0;
    step(1);

`ifdef MODE_8080_EN
    upm = 1'b0; addr_low = 3'b101; icw2 = 8'h12; int_level = 3'd2; int_req = 1'b1; aeoi = 1'b0;
    step(1);
    inta_n = 1'b0;
    step(1);
    m_isr |= 8'h04;
    chk("m80_call", data_out, 8'hCD);
    chk("m80_call_oe", {7'b0, data_oe}, 8'h01);
    int_req = 1'b0; inta_n = 1'b1;
    step(1);
    chk("m80_gap_bus", data_out | {7'b0, data_oe}, 8'h00);
    inta_n = 1'b0;
    step(1);
    chk("m80_low", data_out, 8'hA8);
    inta_n = 1'b1;
    step(2);
    inta_n = 1'b0;
    step(1);
    chk("m80_high", data_out, 8'h12);
    inta_n = 1'b1;
    step(1);
    chk("m80_done", {6'b0, ack_done, freeze}, 8'b10);
    chk("m80_isr", isr, m_isr);
    upm = 1'b1;
    step(1);
`endif

    // Randomized transactions against the model.
    for (int i = 0; i < 16; i++) begin
`ifndef MODE_8080_EN
      upm = 1'($urandom);
`endif
      run_txn(3'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
              1'b0, $urandom_range(0, 30), $urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) do_eoi(3'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
